// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results own the register-file write port, loads queue in a FIFO.
// Define WB_BYPASS_EN to let a load skip an idle FIFO straight into the output register.
module wb_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [2:0]  alu_reg,
  input  logic [15:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [2:0]  ld_reg,
  input  logic [15:0] ld_data,
  output logic        write_en,
  output logic [2:0]  wreg,
  output logic [15:0] writedata,
  output logic [7:0]  pend_mask
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  logic [2:0]       fifo_reg_q  [DEPTH];
  logic [15:0]      fifo_data_q [DEPTH];
  logic [DEPTH-1:0] fifo_live_q, fifo_live_d;
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]    count_q;

  logic fifo_nonempty, head_live, head_dead;
  logic push, pop, bypass;

  assign ld_ready      = count_q < FullCount;
  assign fifo_nonempty = count_q != '0;
  assign head_live     = fifo_nonempty && fifo_live_q[rd_ptr_q];
  assign head_dead     = fifo_nonempty && !fifo_live_q[rd_ptr_q];

`ifdef WB_BYPASS_EN
  // Dead entries never write, so an all-dead FIFO cannot be overtaken out of order.
  assign bypass = ld_valid && ld_ready && !alu_valid && (fifo_live_q == '0);
`else
  assign bypass = 1'b0;
`endif

  assign push = ld_valid && ld_ready && !bypass;
  assign pop  = head_dead || (head_live && !alu_valid);

  // Live bits are cleared on pop, so slots outside the occupied window are always dead.
  always_comb begin
    fifo_live_d = fifo_live_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (alu_valid && (fifo_reg_q[i] == alu_reg)) begin
        fifo_live_d[i] = 1'b0;
      end
    end
    if (pop) begin
      fifo_live_d[rd_ptr_q] = 1'b0;
    end
    if (push) begin
      fifo_live_d[wr_ptr_q] = !(alu_valid && (alu_reg == ld_reg));
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_live_q[i]) begin
        pend_mask[fifo_reg_q[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg_q[wr_ptr_q]  <= ld_reg;
      fifo_data_q[wr_ptr_q] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_live_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      write_en    <= 1'b0;
      wreg        <= '0;
      writedata   <= '0;
    end else begin
      fifo_live_q <= fifo_live_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end

      if (alu_valid) begin
        write_en  <= 1'b1;
        wreg      <= alu_reg;
        writedata <= alu_data;
      end else if (bypass) begin
        write_en  <= 1'b1;
        wreg      <= ld_reg;
        writedata <= ld_data;
      end else if (head_live) begin
        write_en  <= 1'b1;
        wreg      <= fifo_reg_q[rd_ptr_q];
        writedata <= fifo_data_q[rd_ptr_q];
      end else begin
        write_en  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (DEPTH = 4).
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [2:0]  alu_reg;
  logic [15:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  ld_reg;
  logic [15:0] ld_data;
  logic        write_en;
  logic [2:0]  wreg;
  logic [15:0] writedata;
  logic [7:0]  pend_mask;

  int passed = 0;
  int total  = 0;

  wb_arbiter #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_reg   (alu_reg),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_reg    (ld_reg),
    .ld_data   (ld_data),
    .write_en  (write_en),
    .wreg      (wreg),
    .writedata (writedata),
    .pend_mask (pend_mask)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are observed 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [2:0] ar, input logic [15:0] ad,
                       input logic lv, input logic [2:0] lr, input logic [15:0] ldd);
    alu_valid = av;
    alu_reg   = ar;
    alu_data  = ad;
    ld_valid  = lv;
    ld_reg    = lr;
    ld_data   = ldd;
  endtask

  function automatic logic [2:0] full_reg(input int i);
    return (i < 4) ? 3'(i + 1) : 3'd6;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 3'($urandom), 16'($urandom), 1'($urandom), 3'($urandom),
            16'($urandom));
      step();
      total++;
      if ({write_en, wreg, writedata} !== 20'h0)
        $display("FAIL reset_out act=%h req=%h", {write_en, wreg, writedata}, 20'h0);
      else passed++;
      total++;
      if ({ld_ready, pend_mask} !== 9'h100)
        $display("FAIL reset_flags act=%h req=%h", {ld_ready, pend_mask}, 9'h100);
      else passed++;
    end
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    rst_n = 1'b1;
    step();
    drive(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0);
    step();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    total++;
    if ({write_en, wreg, writedata} !== {1'b1, 3'd3, 16'h1234})
      $display("FAIL first_alu act=%h req=%h", {write_en, wreg, writedata},
               {1'b1, 3'd3, 16'h1234});
    else passed++;
    step();
    total++;
    if ({write_en, wreg, writedata} !== {1'b0, 3'd3, 16'h1234})
      $display("FAIL idle_hold act=%h req=%h", {write_en, wreg, writedata},
               {1'b0, 3'd3, 16'h1234});
    else passed++;
  endtask

  task automatic test_priority_drain();
    logic [2:0]  exp_reg  [3];
    logic [15:0] exp_data [3];
    logic [7:0]  exp_mask [3];
    exp_reg  = '{3'd1, 3'd2, 3'd4};
    exp_data = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    exp_mask = '{8'h14, 8'h10, 8'h00};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd5, 16'(16'h5000 + i), 1'b1, exp_reg[i], exp_data[i]);
      step();
      total++;
      if ({write_en, wreg, writedata} !== {1'b1, 3'd5, 16'(16'h5000 + i)})
        $display("FAIL prio_alu%0d act=%h req=%h", i, {write_en, wreg, writedata},
                 {1'b1, 3'd5, 16'(16'h5000 + i)});
      else passed++;
    end
    drive(1'b1, 3'd5, 16'h5003, 1'b0, 3'd0, 16'h0);
    total++;
    if (pend_mask !== 8'h16)
      $display("FAIL prio_mask_full act=%h req=%h", pend_mask, 8'h16);
    else passed++;
    step();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    total++;
    if ({write_en, wreg, pend_mask} !== {1'b1, 3'd5, 8'h16})
      $display("FAIL prio_starve act=%h req=%h", {write_en, wreg, pend_mask},
               {1'b1, 3'd5, 8'h16});
    else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({write_en, wreg, writedata, pend_mask} !== {1'b1, exp_reg[i], exp_data[i], exp_mask[i]})
        $display("FAIL drain%0d act=%h req=%h", i, {write_en, wreg, writedata, pend_mask},
                 {1'b1, exp_reg[i], exp_data[i], exp_mask[i]});
      else passed++;
    end
    step();
    total++;
    if (write_en !== 1'b0) $display("FAIL drain_done act=%b req=0", write_en);
    else passed++;
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd5, 16'(16'h5100 + i), 1'b1, full_reg(i), 16'(16'h1000 + i));
      total++;
      if (ld_ready !== 1'b1) $display("FAIL full_ready%0d act=%b req=1", i, ld_ready);
      else passed++;
      step();
    end
    drive(1'b1, 3'd5, 16'h5104, 1'b1, full_reg(4), 16'h1004);
    total++;
    if (ld_ready !== 1'b0) $display("FAIL full_drop act=%b req=0", ld_ready);
    else passed++;
    step();
    drive(1'b0, 3'd0, 16'h0, 1'b1, full_reg(4), 16'h1004);
    total++;
    if ({ld_ready, pend_mask, write_en, wreg, writedata} !== {1'b0, 8'h1E, 1'b1, 3'd5, 16'h5104})
      $display("FAIL full_hold act=%h req=%h", {ld_ready, pend_mask, write_en, wreg, writedata},
               {1'b0, 8'h1E, 1'b1, 3'd5, 16'h5104});
    else passed++;
    step();
    total++;
    if ({ld_ready, write_en, wreg, writedata} !== {1'b1, 1'b1, full_reg(0), 16'h1000})
      $display("FAIL full_first_pop act=%h req=%h", {ld_ready, write_en, wreg, writedata},
               {1'b1, 1'b1, full_reg(0), 16'h1000});
    else passed++;
    step();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    for (int j = 1; j < 5; j++) begin
      total++;
      if ({write_en, wreg, writedata} !== {1'b1, full_reg(j), 16'(16'h1000 + j)})
        $display("FAIL full_drain%0d act=%h req=%h", j, {write_en, wreg, writedata},
                 {1'b1, full_reg(j), 16'(16'h1000 + j)});
      else passed++;
      step();
    end
    total++;
    if ({write_en, pend_mask, ld_ready} !== {1'b0, 8'h00, 1'b1})
      $display("FAIL full_empty act=%h req=%h", {write_en, pend_mask, ld_ready},
               {1'b0, 8'h00, 1'b1});
    else passed++;
  endtask

  task automatic test_waw();
    drive(1'b1, 3'd3, 16'h0333, 1'b1, 3'd2, 16'h0001);
    step();
    drive(1'b1, 3'd2, 16'h0002, 1'b0, 3'd0, 16'h0);
    total++;
    if ({pend_mask, write_en, wreg, writedata} !== {8'h04, 1'b1, 3'd3, 16'h0333})
      $display("FAIL waw_queued act=%h req=%h", {pend_mask, write_en, wreg, writedata},
               {8'h04, 1'b1, 3'd3, 16'h0333});
    else passed++;
    step();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    total++;
    if ({pend_mask, write_en, wreg, writedata} !== {8'h00, 1'b1, 3'd2, 16'h0002})
      $display("FAIL waw_alu act=%h req=%h", {pend_mask, write_en, wreg, writedata},
               {8'h00, 1'b1, 3'd2, 16'h0002});
    else passed++;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (write_en !== 1'b0) $display("FAIL waw_no_stale%0d act=%b req=0", i, write_en);
      else passed++;
    end
  endtask

  task automatic test_wrap();
    for (int c = 0; c < 23; c++) begin
      if (c == 0) drive(1'b1, 3'd7, 16'h7777, 1'b0, 3'd0, 16'h0);
      else drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
      if (c < 20) begin
        ld_valid = 1'b1;
        ld_reg   = 3'(c % 7);
        ld_data  = 16'(16'h1000 + c * 16'h0357);
      end
      if (c == 1) begin
        total++;
        if ({write_en, wreg, writedata} !== {1'b1, 3'd7, 16'h7777})
          $display("FAIL wrap_alu act=%h req=%h", {write_en, wreg, writedata},
                   {1'b1, 3'd7, 16'h7777});
        else passed++;
      end else if (c >= 2 && c < 22) begin
        total++;
        if ({write_en, wreg, writedata} !== {1'b1, 3'((c - 2) % 7),
                                             16'(16'h1000 + (c - 2) * 16'h0357)})
          $display("FAIL wrap_ld%0d act=%h req=%h", c - 2, {write_en, wreg, writedata},
                   {1'b1, 3'((c - 2) % 7), 16'(16'h1000 + (c - 2) * 16'h0357)});
        else passed++;
      end else if (c == 22) begin
        total++;
        if (write_en !== 1'b0) $display("FAIL wrap_done act=%b req=0", write_en);
        else passed++;
      end
      step();
    end
    drive(1'b1, 3'd6, 16'h0606, 1'b1, 3'd6, 16'h6666);
    step();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    total++;
    if ({pend_mask, write_en, wreg, writedata} !== {8'h00, 1'b1, 3'd6, 16'h0606})
      $display("FAIL same_kill_alu act=%h req=%h", {pend_mask, write_en, wreg, writedata},
               {8'h00, 1'b1, 3'd6, 16'h0606});
    else passed++;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (write_en !== 1'b0) $display("FAIL same_kill_none%0d act=%b req=0", i, write_en);
      else passed++;
    end
  endtask

  task automatic test_bypass();
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 16'h5555);
    step();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
`ifdef WB_BYPASS_EN
    total++;
    if ({pend_mask, write_en, wreg, writedata} !== {8'h00, 1'b1, 3'd7, 16'h5555})
      $display("FAIL bypass_write act=%h req=%h", {pend_mask, write_en, wreg, writedata},
               {8'h00, 1'b1, 3'd7, 16'h5555});
    else passed++;
`else
    total++;
    if ({pend_mask, write_en} !== {8'h80, 1'b0})
      $display("FAIL nobypass_queued act=%h req=%h", {pend_mask, write_en}, {8'h80, 1'b0});
    else passed++;
    step();
    total++;
    if ({pend_mask, write_en, wreg, writedata} !== {8'h00, 1'b1, 3'd7, 16'h5555})
      $display("FAIL nobypass_write act=%h req=%h", {pend_mask, write_en, wreg, writedata},
               {8'h00, 1'b1, 3'd7, 16'h5555});
    else passed++;
`endif
    step();
    total++;
    if (write_en !== 1'b0) $display("FAIL bypass_done act=%b req=0", write_en);
    else passed++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd5, 16'h5A5A, 1'b1, full_reg(i), 16'(16'h2000 + i));
      step();
    end
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    total++;
    if (pend_mask !== 8'h0E) $display("FAIL mid_pre_mask act=%h req=%h", pend_mask, 8'h0E);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({write_en, wreg, writedata, pend_mask, ld_ready} !== {1'b0, 3'd0, 16'h0, 8'h00, 1'b1})
      $display("FAIL mid_reset act=%h req=%h", {write_en, wreg, writedata, pend_mask, ld_ready},
               {1'b0, 3'd0, 16'h0, 8'h00, 1'b1});
    else passed++;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (write_en !== 1'b0) $display("FAIL mid_discard%0d act=%b req=0", i, write_en);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_priority_drain();
    test_full();
    test_waw();
    test_wrap();
    test_bypass();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter sitting directly upstream of the 8×16 register file's single write port. Merges single-cycle ALU results with variable-latency load results into one registered write stream (`write_en`/`wreg`/`writedata`), matching the register file's write interface. ALU results always win the port; load results queue in a small FIFO and drain on free cycles. Also tracks registers with queued writes so issue logic can stall on them.

## Interface
Parameters:
- `DEPTH`, 4, load FIFO entries (power of two, 2..16)

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `alu_valid`  in  1  ALU result present this cycle (no backpressure)
- `alu_reg`  in  3  ALU destination register
- `alu_data`  in  16  ALU result
- `ld_valid`  in  1  load result offered
- `ld_ready`  out  1  FIFO can accept; `count < DEPTH`, combinational
- `ld_reg`  in  3  load destination register
- `ld_data`  in  16  load result
- `write_en`  out  1  register file write strobe (registered)
- `wreg`  out  3  register file write address (registered)
- `writedata`  out  16  register file write data (registered)
- `pend_mask`  out  8  bit r set if a live queued load targets register r

## Operation
- Load accepted on edge when `ld_valid && ld_ready`; stored as {reg, data, live=1} at FIFO tail.
- Per-cycle port selection, priority order:
  1. `alu_valid`: output register loads {1, alu_reg, alu_data}.
  2. Else FIFO head live: output loads {1, head reg, head data}; head popped.
  3. Else output `write_en` <= 0; `wreg`/`writedata` hold.
- Dead head (live=0) popped in any cycle, even when ALU wins; never produces a write.
- WAW kill: `alu_valid` with `alu_reg`=r clears live on every queued entry with reg r, including a load accepted in the same cycle. Contract: an ALU result is always younger than any load accepted in the same or earlier cycle.
- `pend_mask` = OR over live entries of one-hot(reg); combinational from FIFO state; excludes the output register.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; `count` is log2(DEPTH)+1 bits.
- Simultaneous push and pop: count unchanged; a push into a full FIFO is impossible because ready already dropped (ready does not look ahead to a pop).

## Timing
- ALU result presented in cycle N -> `write_en` high in cycle N+1.
- Load accepted at the edge ending cycle N, FIFO otherwise empty, no ALU in N+1 -> `write_en` in cycle N+2.
- Sustained ALU traffic starves loads; FIFO fills and `ld_ready` drops at `count == DEPTH`.
- Reset (async assert, sync-safe release): `write_en`=0, `wreg`=0, `writedata`=0, FIFO empty, `pend_mask`=0, `ld_ready`=1. Reset mid-operation discards all queued loads; no partial write is emitted.

## Configuration
- `WB_BYPASS_EN` defined: a load offered while the FIFO is empty (or holds only dead entries about to pop) and `alu_valid`=0 goes straight to the output register, with `write_en` in cycle N+1. It is not enqueued and never appears in `pend_mask`.
- `WB_BYPASS_EN` undefined: every load goes through the FIFO, with a minimum latency of 2 cycles.

## Test plan
- Reset: hold `rst_n`=0 with random inputs -> `write_en`=0, `wreg`=0, `writedata`=0, `pend_mask`=0, `ld_ready`=1. Release -> first ALU {r3, 0x1234} -> `write_en`=1, `wreg`=3, `writedata`=0x1234 one cycle later.
- Priority and drain: 3 loads {r1,0xAAAA}, {r2,0xBBBB}, {r4,0xCCCC} accepted under continuous ALU writes to r5 -> only r5 writes appear. ALU stops -> r1, r2, r4 written in order on 3 consecutive cycles; `pend_mask` steps 0x16 -> 0x14 -> 0x10 -> 0x00.
- Full: DEPTH=4, ALU busy, offer 5 loads -> `ld_ready`=0 after the 4th accept. The 5th is accepted only in the cycle after the first pop.
- WAW kill: queue {r2,0x0001}, then ALU {r2,0x0002} -> `pend_mask[2]` clears, the single r2 write is 0x0002, and the queued value is never written.
- Wrap and same-cycle kill: push/pop 20 loads to exercise pointer wrap, with data integrity checked. Then load {r6} and ALU {r6} in the same cycle -> only the ALU write to r6 occurs.
- Bypass (`WB_BYPASS_EN`): empty FIFO, load {r7,0x5555} with no ALU -> `write_en` next cycle with `pend_mask`=0. Without the macro, the same stimulus writes 2 cycles after accept and `pend_mask[7]` is high for one cycle.
